// File: rtl/game_ctrl_fsm.sv
// Game sequencer: owns game_state, generates the one-cycle scroll tick (game_clk),
// and keeps score, high score and the shrinking tick period.
module game_ctrl_fsm #(
    parameter int INIT_PERIOD   = 500000,
    parameter int MIN_PERIOD    = 200000,
    parameter int PERIOD_STEP   = 25000,
    parameter int SCORE_DIV     = 10,
    parameter int SPEEDUP_EVERY = 100,
    parameter int SCORE_MAX     = 9999,
    parameter int RESET_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_btn,
    input  logic        collision,
    output logic [1:0]  game_state,
    output logic        game_clk,
    output logic [13:0] score,
    output logic [13:0] high_score,
    output logic [19:0] period
);

    localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int SPD_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCORE_DIV - 1);
    localparam logic [SPD_W-1:0] SPD_LAST = SPD_W'(SPEEDUP_EVERY - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [19:0]      P_INIT   = 20'(INIT_PERIOD);
    localparam logic [19:0]      P_MIN    = 20'(MIN_PERIOD);
    localparam logic [19:0]      P_STEP   = 20'(PERIOD_STEP);
    localparam logic [19:0]      P_FLOOR  = 20'(MIN_PERIOD + PERIOD_STEP);
    localparam logic [13:0]      S_MAX    = 14'(SCORE_MAX);

    // Encoding is shared with the renderers; all four codes are legal.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_START = 2'd1,
        ST_END   = 2'd2,
        ST_RESET = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              btn_q;
    logic              game_clk_q, game_clk_d;
    logic [19:0]       cnt_q, cnt_d;
    logic [19:0]       period_q, period_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SPD_W-1:0]  spd_q, spd_d;
    logic [RST_W-1:0]  rcnt_q, rcnt_d;
    logic [13:0]       score_q, score_d;
    logic [13:0]       high_q, high_d;
    logic              btn_rise;
    logic              tick;

    always_comb begin
        state_d    = state_q;
        game_clk_d = 1'b0;
        cnt_d      = cnt_q;
        period_d   = period_q;
        div_d      = div_q;
        spd_d      = spd_q;
        rcnt_d     = rcnt_q;
        score_d    = score_q;
        high_d     = high_q;
        btn_rise   = jump_btn & ~btn_q;
        tick       = (cnt_q == period_q - 20'd1);

        case (state_q)
            ST_INIT: begin
                cnt_d = '0;
                div_d = '0;
                if (btn_rise) state_d = ST_START;
            end
            ST_START: begin
                if (collision) begin
                    state_d = ST_END;
                    high_d  = (score_q > high_q) ? score_q : high_q;
                end else if (tick) begin
                    cnt_d      = '0;
                    game_clk_d = 1'b1;
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        // Speed-up rides on score increments, so it stops with saturation.
                        if (score_q < S_MAX) begin
                            score_d = score_q + 14'd1;
                            if (spd_q == SPD_LAST) begin
                                spd_d    = '0;
                                period_d = (period_q >= P_FLOOR) ? period_q - P_STEP : P_MIN;
                            end else begin
                                spd_d = spd_q + 1'b1;
                            end
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            ST_END: begin
                if (btn_rise) begin
                    state_d  = ST_RESET;
                    score_d  = '0;
                    period_d = P_INIT;
                    cnt_d    = '0;
                    div_d    = '0;
                    spd_d    = '0;
                    rcnt_d   = '0;
                end
            end
            default: begin
                score_d  = '0;
                period_d = P_INIT;
                cnt_d    = '0;
                div_d    = '0;
                spd_d    = '0;
                if (rcnt_q == RST_LAST) begin
                    state_d = ST_INIT;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            btn_q      <= 1'b0;
            game_clk_q <= 1'b0;
            cnt_q      <= '0;
            period_q   <= P_INIT;
            div_q      <= '0;
            spd_q      <= '0;
            rcnt_q     <= '0;
            score_q    <= '0;
            high_q     <= '0;
        end else begin
            state_q    <= state_d;
            btn_q      <= jump_btn;
            game_clk_q <= game_clk_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            div_q      <= div_d;
            spd_q      <= spd_d;
            rcnt_q     <= rcnt_d;
            score_q    <= score_d;
            high_q     <= high_d;
        end
    end

    assign game_state = state_q;
    assign game_clk   = game_clk_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign period     = period_q;

endmodule
